gly_axil_regbank: RTL and testbench
===================================

// Module: gly_axil_regbank
// PURPOSE
//  Parametrised AXI4-Lite slave register bank; successor to the fixed 4x32 gly_v5_0 slave.
//  Adds configurable register count/width, WSTRB byte enables, read-only (hardware-fed) registers,
//  SLVERR decode, per-register write pulses. Sits behind the PS/VIP master in the block design.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32            data width; 32 or 64 only
//  N_REGS              8             register count, 2..64
//  C_S_AXI_ADDR_WIDTH  6             byte address width; must be >= clog2(N_REGS)+clog2(DW/8)
//  RO_MASK             '0            N_REGS bits; bit i=1 -> reg i read-only, returns reg_in slice i
//  RESET_VAL           '0            N_REGS*DW bits; reset value of reg i in slice i
// PORTS
//  S_AXI_ACLK     in   1        clock
//  S_AXI_ARESETN  in   1        async active-low reset
//  S_AXI_AWADDR   in   AW       write address (byte)
//  S_AXI_AWPROT   in   3        ignored
//  S_AXI_AWVALID/AWREADY  in/out 1  write-address handshake
//  S_AXI_WDATA    in   DW       write data
//  S_AXI_WSTRB    in   DW/8     byte enables
//  S_AXI_WVALID/WREADY    in/out 1  write-data handshake
//  S_AXI_BRESP    out  2        OKAY 2'b00 / SLVERR 2'b10
//  S_AXI_BVALID/BREADY    out/in 1  write response
//  S_AXI_ARADDR   in   AW       read address; S_AXI_ARPROT in 3 ignored
//  S_AXI_ARVALID/ARREADY  in/out 1  read-address handshake
//  S_AXI_RDATA    out  DW       read data;  S_AXI_RRESP out 2
//  S_AXI_RVALID/RREADY    out/in 1  read response
//  reg_out        out  N_REGS*DW  current RW register contents (RO slices drive 0)
//  reg_in         in   N_REGS*DW  hardware values for RO registers
//  reg_wr_pulse   out  N_REGS   1-cycle pulse the cycle after reg i is written
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): AWREADY/WREADY/ARREADY=0 first cycle then 1;
//   BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg_wr_pulse=0, regs=RESET_VAL. Mid-transaction
//   reset drops all pending AW/W/B/R; no partial write survives.
//  Write path: AW and W captured independently (either order, same cycle allowed) into holding regs;
//   AWREADY low while AW held or BVALID=1; WREADY likewise for W. Cycle after both held: commit,
//   BVALID=1 (write latency 1 clk from last of AW/W handshake). BVALID,BRESP held until BREADY.
//   One outstanding write. FSM: WR_IDLE -> WR_RESP (both captured) -> WR_IDLE (BVALID&BREADY).
//  Index = addr[AW-1:clog2(DW/8)]; low byte-offset bits ignored. Index >= N_REGS -> no update,
//   BRESP=SLVERR, no pulse. RO index -> no update, BRESP=OKAY, no pulse. Else bytes with WSTRB=1
//   updated; pulse asserted even when WSTRB=0.
//  Read path: ARREADY=1 when RVALID=0. On AR handshake, RDATA/RRESP registered next cycle with
//   RVALID=1; held until RREADY. Out-of-range -> RDATA=0, RRESP=SLVERR. RO -> reg_in slice.
//   FSM: RD_IDLE -> RD_RESP -> RD_IDLE. One outstanding read.
//  Write commit and read sample on same edge, same index -> read returns pre-write value.
//  Read and write channels fully independent; no ordering between them.
// STRUCTURE
//  gly_axil_pkg: axi_resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), wr_state_t, rd_state_t,
//   function idx_of(addr). Single sub-module gly_axil_wstrb_merge (old,new,strb -> merged word).
// TESTING
//  Defaults; write 1..8 to 0x00..0x1C, read back -> RDATA 1..8, all RESP OKAY.
//  Write 0xFFFFFFFF to 0x04, then 0xA5A5A5A5 with WSTRB=4'b0101 -> read 0xFFA5FFA5.
//  Present W 3 cycles before AW -> single commit, BVALID 1 clk after AW handshake, one pulse.
//  Write/read addr 0x20 (N_REGS=8) -> BRESP=SLVERR, RDATA=0, RRESP=SLVERR, no reg change.
//  RO_MASK=8'h02, reg_in slice1=0xDEADBEEF; write 0x04 -> OKAY, no pulse; read -> 0xDEADBEEF.
//  Hold BREADY/RREADY low 10 clk -> BVALID/RVALID stable, AWREADY/WREADY/ARREADY stay 0;
//   assert ARESETN low mid-wait -> valids drop asynchronously, regs return to RESET_VAL.

Source files
------------

// File: rtl/gly_axil_pkg.sv
// Shared types and helpers for the gly AXI4-Lite register bank.
package gly_axil_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_t;

  typedef logic [0:0] wr_state_t;
  localparam wr_state_t WR_IDLE = 1'b0;
  localparam wr_state_t WR_RESP = 1'b1;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_RESP = 1'b1;

  // Word index of a byte address; lsb is log2 of the bytes per word.
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/gly_axil_wstrb_merge.sv
// Byte-lane merge: lanes with strb set take the new word, the rest keep the old word.
module gly_axil_wstrb_merge #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int b = 0; b < int'(DW / 8); b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
  end

endmodule

// File: rtl/gly_axil_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte enables, read-only
// hardware-fed registers, SLVERR decode and per-register write pulses.
module gly_axil_regbank
  import gly_axil_pkg::*;
#(
  parameter int unsigned                                  C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned                                  N_REGS             = 8,
  parameter int unsigned                                  C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [N_REGS-1:0]                            RO_MASK            = '0,
  parameter logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0]         RESET_VAL          = '0
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  input  logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_in,
  output logic [N_REGS-1:0]                      reg_wr_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(SW);

  logic              init_q;
  logic [DW-1:0]     regs_q [N_REGS];

  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_held_q, w_held_q;
  logic [AW-1:0]     aw_addr_q;
  logic [DW-1:0]     wdata_q;
  logic [SW-1:0]     wstrb_q;
  axi_resp_t         bresp_q;
  logic [N_REGS-1:0] pulse_q;

  rd_state_t         rd_state_q, rd_state_d;
  logic [DW-1:0]     rdata_q;
  axi_resp_t         rresp_q;

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [31:0]       aw_idx, ar_idx;
  logic              aw_in_range, ar_in_range;
  logic [N_REGS-1:0] wr_en;
  logic [DW-1:0]     old_word, merged, rd_word;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Ready is held off for the first cycle after reset release.
  assign S_AXI_AWREADY = init_q & ~aw_held_q & (wr_state_q == WR_IDLE);
  assign S_AXI_WREADY  = init_q & ~w_held_q & (wr_state_q == WR_IDLE);
  assign S_AXI_ARREADY = init_q & (rd_state_q == RD_IDLE);
  assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = (wr_state_q == WR_IDLE) & aw_held_q & w_held_q;

  assign aw_idx = idx_of(32'(aw_addr_q), ADDR_LSB);
  assign ar_idx = idx_of(32'(S_AXI_ARADDR), ADDR_LSB);

  // Write decode: RO and out-of-range targets never get an enable.
  always_comb begin
    wr_en       = '0;
    old_word    = '0;
    aw_in_range = 1'b0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      if (aw_idx == 32'(i)) begin
        aw_in_range = 1'b1;
        old_word    = regs_q[i];
        wr_en[i]    = commit & ~RO_MASK[i];
      end
    end
  end

  always_comb begin
    rd_word     = '0;
    ar_in_range = 1'b0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      if (ar_idx == 32'(i)) begin
        ar_in_range = 1'b1;
        rd_word     = RO_MASK[i] ? reg_in[i*DW +: DW] : regs_q[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      reg_out[i*DW +: DW] = regs_q[i];
    end
  end

  gly_axil_wstrb_merge #(
    .DW (DW)
  ) u_merge (
    .old_word (old_word),
    .new_word (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_IDLE: if (commit) wr_state_d = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (ar_hs) rd_state_d = RD_RESP;
      RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      init_q     <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
      pulse_q    <= '0;
    end else begin
      init_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      pulse_q    <= wr_en;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= aw_in_range ? RespOkay : RespSlverr;
      end
    end
  end

  // RO slots hold zero so reg_out reports 0 for them.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DW +: DW];
      end
    end else begin
      for (int i = 0; i < int'(N_REGS); i++) begin
        if (wr_en[i]) regs_q[i] <= merged;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= ar_in_range ? RespOkay : RespSlverr;
      end
    end
  end

endmodule

// File: tb/tb_gly_axil_regbank.sv
// Randomised self-checking bench for gly_axil_regbank against a word-array model.
module tb_gly_axil_regbank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;
  localparam logic [NR-1:0] RO = 8'h02;
  localparam logic [NR*DW-1:0] RV = {32'h8888_0808, 32'h7777_0707, 32'h6666_0606, 32'h5555_0505,
                                     32'h4444_0404, 32'h3333_0303, 32'h2222_0202, 32'h1111_0101};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = 3'b000, arprot = 3'b000;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in = '0;
  logic [NR-1:0] reg_wr_pulse;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] mdl [NR];
  int pulse_exp [NR] = '{default: 0};
  int pulse_seen [NR] = '{default: 0};
  logic [1:0] pend_bresp, pend_rresp;
  logic [DW-1:0] pend_rdata;

  always #5 clk = ~clk;

  gly_axil_regbank #(
    .C_S_AXI_DATA_WIDTH (DW),
    .N_REGS             (NR),
    .C_S_AXI_ADDR_WIDTH (AW),
    .RO_MASK            (RO),
    .RESET_VAL          (RV)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) if (reg_wr_pulse[i]) pulse_seen[i]++;
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RO[i] ? '0 : RV[i*DW +: DW];
  endfunction

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
    return v;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                                      input logic [3:0] s, output logic [1:0] resp,
                                      output logic [NR-1:0] pl);
    int idx;
    idx = int'(addr) / 4;
    pl = '0;
    resp = 2'b00;
    if (idx >= NR) resp = 2'b10;
    else if (!RO[idx]) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      pl[idx] = 1'b1;
      pulse_exp[idx]++;
    end
  endfunction

  function automatic void model_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                                     output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    d = '0;
    resp = 2'b00;
    if (idx >= NR) resp = 2'b10;
    else if (RO[idx]) d = reg_in[idx*DW +: DW];
    else d = mdl[idx];
  endfunction

  task automatic check_regout(input string name);
    total++;
    if (reg_out !== model_vec()) begin
      bad++;
      $display("FAIL regout_%s: got %h want %h", name, reg_out, model_vec());
    end
  endtask

  task automatic check_pulses();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (pulse_seen[i] != pulse_exp[i]) begin
        ok = 1'b0;
        $display("FAIL pulse_count reg%0d: got %0d want %0d", i, pulse_seen[i], pulse_exp[i]);
      end
    end
    total++;
    if (!ok) bad++;
  endtask

  // Drives AW and W with independent delays; returns at the negedge BVALID is seen.
  task automatic wr_issue(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_f, w_f;
    int cyc, wt;
    logic [NR-1:0] exp_pl;
    aw_done = 1'b0;
    w_done = 1'b0;
    cyc = 0;
    wt = 0;
    model_write(addr, data, strb, pend_bresp, exp_pl);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      awaddr = addr;
      wdata = data;
      wstrb = strb;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      if (aw_done) begin
        total++;
        if (awready !== 1'b0) begin
          bad++;
          $display("FAIL awready_held: got %b want 0", awready);
        end
      end
      if (w_done) begin
        total++;
        if (wready !== 1'b0) begin
          bad++;
          $display("FAIL wready_held: got %b want 0", wready);
        end
      end
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      @(posedge clk);
      if (aw_f) aw_done = 1'b1;
      if (w_f) w_done = 1'b1;
      cyc++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    while (bvalid !== 1'b1 && wt < 20) begin
      wt++;
      @(negedge clk);
    end
    total++;
    if (wt != 1) begin
      bad++;
      $display("FAIL b_latency addr %h: got %0d cycles want 1", addr, wt);
    end
    total++;
    if (reg_wr_pulse !== exp_pl) begin
      bad++;
      $display("FAIL wr_pulse addr %h: got %b want %b", addr, reg_wr_pulse, exp_pl);
    end
  endtask

  task automatic wr_finish(input int stall);
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== pend_bresp || awready !== 1'b0 || wready !== 1'b0)
        stable = 1'b0;
    end
    if (stall > 0) begin
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL b_stall: got unstable want stable");
      end
    end
    total++;
    if (bresp !== pend_bresp) begin
      bad++;
      $display("FAIL bresp: got %b want %b", bresp, pend_bresp);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0 || reg_wr_pulse !== '0) begin
      bad++;
      $display("FAIL b_done: got bvalid=%b pulse=%b want 0/0", bvalid, reg_wr_pulse);
    end
  endtask

  task automatic rd_issue(input logic [AW-1:0] addr);
    int wt;
    wt = 0;
    model_read(addr, pend_rdata, pend_rresp);
    @(negedge clk);
    araddr = addr;
    arvalid = 1'b1;
    while (arready !== 1'b1 && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1) begin
      bad++;
      $display("FAIL r_latency addr %h: got rvalid=%b want 1", addr, rvalid);
    end
  endtask

  task automatic rd_finish(input int stall);
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== pend_rdata || rresp !== pend_rresp || arready !== 1'b0)
        stable = 1'b0;
    end
    if (stall > 0) begin
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL r_stall: got unstable want stable");
      end
    end
    total++;
    if (rdata !== pend_rdata) begin
      bad++;
      $display("FAIL rdata addr %h: got %h want %h", araddr, rdata, pend_rdata);
    end
    total++;
    if (rresp !== pend_rresp) begin
      bad++;
      $display("FAIL rresp addr %h: got %b want %b", araddr, rresp, pend_rresp);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    total++;
    if (rvalid !== 1'b0) begin
      bad++;
      $display("FAIL r_done: got %b want 0", rvalid);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== '0 || reg_wr_pulse !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b %b %b %b %h %b want zeros",
               bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse);
    end
    check_regout("reset");
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++;
      $display("FAIL ready_in_reset: got %b want 000", {awready, wready, arready});
    end
    rst_n = 1'b1;
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++;
      $display("FAIL ready_first_cycle: got %b want 000", {awready, wready, arready});
    end
    @(negedge clk);
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_reset: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < NR; i++) begin
      wr_issue(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0);
      wr_finish(0);
    end
    for (int i = 0; i < NR; i++) begin
      rd_issue(AW'(i * 4));
      rd_finish(0);
    end
    check_regout("fill");
  endtask

  task automatic test_wstrb();
    wr_issue(6'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr_finish(0);
    wr_issue(6'h0C, 32'hA5A5_A5A5, 4'b0101, 0, 0);
    wr_finish(0);
    rd_issue(6'h0C);
    total++;
    if (rdata !== 32'hFFA5_FFA5) begin
      bad++;
      $display("FAIL wstrb_merge: got %h want ffa5ffa5", rdata);
    end
    rd_finish(0);
    wr_issue(6'h0E, 32'h0000_0000, 4'b0000, 1, 0);
    wr_finish(0);
    rd_issue(6'h0C);
    rd_finish(0);
    check_regout("wstrb");
  endtask

  task automatic test_w_first();
    wr_issue(6'h10, 32'h0BAD_F00D, 4'hF, 3, 0);
    wr_finish(0);
    wr_issue(6'h14, 32'h1234_5678, 4'b1100, 0, 2);
    wr_finish(0);
    check_regout("w_first");
    check_pulses();
  endtask

  task automatic test_out_of_range();
    wr_issue(6'h20, 32'hCAFE_CAFE, 4'hF, 0, 0);
    total++;
    if (bresp !== 2'b10) begin
      bad++;
      $display("FAIL oor_bresp: got %b want 10", bresp);
    end
    wr_finish(0);
    rd_issue(6'h20);
    total++;
    if (rdata !== '0 || rresp !== 2'b10) begin
      bad++;
      $display("FAIL oor_read: got %h/%b want 0/10", rdata, rresp);
    end
    rd_finish(0);
    wr_issue(6'h3F, 32'h1111_2222, 4'hF, 1, 1);
    wr_finish(0);
    rd_issue(6'h3D);
    rd_finish(0);
    check_regout("oor");
  endtask

  task automatic test_ro();
    wr_issue(6'h04, 32'h1234_5678, 4'hF, 0, 0);
    wr_finish(0);
    rd_issue(6'h04);
    total++;
    if (rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ro_read: got %h want deadbeef", rdata);
    end
    rd_finish(0);
    reg_in[DW +: DW] = 32'hCAFE_F00D;
    rd_issue(6'h05);
    rd_finish(0);
    check_regout("ro");
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] old, nw;
    logic [1:0] r;
    logic [NR-1:0] pl;
    old = mdl[2];
    nw = $urandom;
    @(negedge clk);
    awaddr = 6'h08;
    wdata = nw;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL same_edge_ready: got %b want 111", {awready, wready, arready});
    end
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = 6'h08;
    arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      bad++;
      $display("FAIL same_edge_read: got %b/%h want 1/%h", rvalid, rdata, old);
    end
    model_write(6'h08, nw, 4'hF, r, pl);
    total++;
    if (bvalid !== 1'b1 || bresp !== r || reg_wr_pulse !== pl) begin
      bad++;
      $display("FAIL same_edge_write: got %b/%b/%b want 1/%b/%b", bvalid, bresp, reg_wr_pulse,
               r, pl);
    end
    bready = 1'b1;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
    rd_issue(6'h08);
    rd_finish(0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 50; n++) begin
      a = AW'($urandom_range(0, 47));
      if ($urandom_range(0, 4) == 0) reg_in[$urandom_range(0, NR - 1) * DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wr_issue(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3));
        wr_finish($urandom_range(0, 2));
      end else begin
        rd_issue(a);
        rd_finish($urandom_range(0, 2));
      end
      if (n % 10 == 9) check_regout("random");
    end
    check_pulses();
  endtask

  task automatic test_stall_reset();
    bit stable;
    wr_issue(6'h14, 32'h1357_9BDF, 4'hF, 0, 0);
    rd_issue(6'h00);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || {awready, wready, arready} !== 3'b000 ||
          rdata !== pend_rdata || bresp !== pend_bresp)
        stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL stall_hold: got unstable want stable");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_valids: got %b/%b want 0/0", bvalid, rvalid);
    end
    model_reset();
    check_regout("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    awaddr = 6'h08;
    awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    total++;
    if (awready !== 1'b0 || wready !== 1'b1) begin
      bad++;
      $display("FAIL aw_only_held: got %b/%b want 0/1", awready, wready);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_issue(6'h18, 32'h2468_ACE0, 4'hF, 0, 0);
    wr_finish(0);
    check_regout("aw_dropped");
    check_pulses();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = $urandom;
    reg_in[DW +: DW] = 32'hDEAD_BEEF;
    test_reset();
    test_fill();
    test_wstrb();
    test_w_first();
    test_out_of_range();
    test_ro();
    test_same_edge();
    test_random();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
